// File: rtl/bcd_stopwatch_scan.sv
// BCD stopwatch with per-digit 0..9 / 0..5 wrap and a scanned digit output.
// Build option: define BLANK_LZ_EN to blank leading zeros on the scan output.
module bcd_stopwatch_scan #(
    parameter int         NUM_DIGITS = 4,
    parameter int         TICK_DIV   = 1_000_000,
    parameter int         SCAN_DIV   = 10_000,
    parameter logic [7:0] SEXA_MASK  = 8'h04
) (
    input  logic                    clk_wiz,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    clear,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    running,
    output logic                    ovf,
    output logic [2:0]              an,
    output logic [3:0]              d
);

    localparam int BW = 4 * NUM_DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [BW-1:0] bcd_q, bcd_d;
    logic [BW-1:0] inc_val, clamp_val;
    logic [PW-1:0] presc_q, presc_d;
    logic          run_q, run_d;
    logic          ovf_q, ovf_d;
    logic          all_max;
    logic          tick;

    logic [SW-1:0] scan_q, scan_d;
    logic [2:0]    slot_q, slot_d;
    logic [2:0]    an_q;
    logic [3:0]    d_q, d_d;
    logic [3:0]    sel;

    function automatic logic [3:0] digit_max(input int i);
        return SEXA_MASK[i] ? 4'd5 : 4'd9;
    endfunction

    assign tick = run_q && (presc_q == PW'(TICK_DIV - 1));

    // Cascaded increment and load clamping, one nibble at a time.
    always_comb begin
        logic [3:0] cur;
        logic [3:0] mx;
        logic       carry;
        inc_val   = bcd_q;
        clamp_val = load_val;
        carry     = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            cur = bcd_q[4*i +: 4];
            mx  = digit_max(i);
            if (carry)
                inc_val[4*i +: 4] = (cur == mx) ? 4'd0 : cur + 4'd1;
            carry = carry && (cur == mx);
            if (load_val[4*i +: 4] > mx)
                clamp_val[4*i +: 4] = mx;
        end
        all_max = carry;
    end

    // Control priority: clear, then load, then stop, then start, then tick.
    always_comb begin
        bcd_d   = bcd_q;
        presc_d = presc_q;
        run_d   = run_q;
        ovf_d   = 1'b0;
        if (clear) begin
            bcd_d   = '0;
            presc_d = '0;
        end else if (load) begin
            bcd_d   = clamp_val;
            presc_d = '0;
        end else begin
            if (stop)
                run_d = 1'b0;
            else if (start)
                run_d = 1'b1;
            if (tick) begin
                bcd_d   = inc_val;
                ovf_d   = all_max;
                presc_d = '0;
            end else if (run_q) begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // Counting state registers.
    always_ff @(posedge clk_wiz) begin
        if (rst) begin
            bcd_q   <= '0;
            presc_q <= '0;
            run_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            bcd_q   <= bcd_d;
            presc_q <= presc_d;
            run_q   <= run_d;
            ovf_q   <= ovf_d;
        end
    end

    // Free-running scan divider and slot sequencer.
    always_comb begin
        scan_d = scan_q + 1'b1;
        slot_d = slot_q;
        if (scan_q == SW'(SCAN_DIV - 1)) begin
            scan_d = '0;
            slot_d = (slot_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : slot_q + 3'd1;
        end
    end

    // Digit selected by the current slot.
    always_comb begin
        sel = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (slot_q == 3'(i))
                sel = bcd_q[4*i +: 4];
        end
    end

`ifdef BLANK_LZ_EN
    // Blank the slot when it and every more-significant digit is zero.
    always_comb begin
        logic upz;
        logic blank;
        upz   = 1'b1;
        blank = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upz = upz && (bcd_q[4*i +: 4] == 4'd0);
            if (slot_q == 3'(i))
                blank = upz && (i != 0);
        end
        d_d = blank ? 4'hF : sel;
    end
`else
    // Show the selected digit unmodified.
    always_comb begin
        d_d = sel;
    end
`endif

    // Scan state and registered display outputs.
    always_ff @(posedge clk_wiz) begin
        if (rst) begin
            scan_q <= '0;
            slot_q <= 3'd0;
            an_q   <= 3'd0;
            d_q    <= 4'd0;
        end else begin
            scan_q <= scan_d;
            slot_q <= slot_d;
            an_q   <= slot_q;
            d_q    <= d_d;
        end
    end

    assign bcd_out = bcd_q;
    assign running = run_q;
    assign ovf     = ovf_q;
    assign an      = an_q;
    assign d       = d_q;

endmodule

// File: tb/tb_bcd_stopwatch_scan.sv
// Directed bench for bcd_stopwatch_scan (4 digits, tick every 4, scan every 2).
// Expected values are hand-derived from the counting and scan rules.
module tb_bcd_stopwatch_scan;

    logic        clk_wiz = 1'b0;
    logic        rst, start, stop, clear, load;
    logic [15:0] load_val;
    logic [15:0] bcd_out;
    logic        running, ovf;
    logic [2:0]  an;
    logic [3:0]  d;

    int total = 0;
    int bad   = 0;

    always #5 clk_wiz = ~clk_wiz;

    bcd_stopwatch_scan #(
        .NUM_DIGITS(4),
        .TICK_DIV  (4),
        .SCAN_DIV  (2),
        .SEXA_MASK (8'h04)
    ) dut (
        .clk_wiz (clk_wiz),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .clear   (clear),
        .load    (load),
        .load_val(load_val),
        .bcd_out (bcd_out),
        .running (running),
        .ovf     (ovf),
        .an      (an),
        .d       (d)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk_wiz);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; stop = 0; clear = 0; load = 0;
        load_val = 16'h0000;
        step(2);
        total++;
        if (bcd_out !== 16'h0000) begin
            bad++; $display("FAIL reset_bcd got=%h want=0000", bcd_out);
        end
        total++;
        if (running !== 1'b0 || ovf !== 1'b0) begin
            bad++; $display("FAIL reset_flags got run=%b ovf=%b want 0 0", running, ovf);
        end
        total++;
        if (an !== 3'd0 || d !== 4'd0) begin
            bad++; $display("FAIL reset_scan got an=%0d d=%h want 0 0", an, d);
        end
        rst = 1'b0;
    endtask

    task automatic test_count();
        start = 1'b1; step(1); start = 1'b0;
        step(38);
        total++;
        if (bcd_out !== 16'h0009) begin
            bad++; $display("FAIL count_39 got=%h want=0009", bcd_out);
        end
        step(2);
        total++;
        if (bcd_out !== 16'h0010) begin
            bad++; $display("FAIL count_40 got=%h want=0010", bcd_out);
        end
        total++;
        if (running !== 1'b1) begin
            bad++; $display("FAIL count_run got=%b want=1", running);
        end
        stop = 1'b1; step(1); stop = 1'b0;
        total++;
        if (running !== 1'b0) begin
            bad++; $display("FAIL stop got=%b want=0", running);
        end
    endtask

    task automatic test_sexa_wrap();
        load_val = 16'h0599; load = 1'b1; step(1); load = 1'b0;
        total++;
        if (bcd_out !== 16'h0599) begin
            bad++; $display("FAIL load_0599 got=%h want=0599", bcd_out);
        end
        start = 1'b1; step(1); start = 1'b0;
        step(3);
        total++;
        if (bcd_out !== 16'h0599 || ovf !== 1'b0) begin
            bad++; $display("FAIL sexa_pre got=%h ovf=%b want=0599 0", bcd_out, ovf);
        end
        step(1);
        total++;
        if (bcd_out !== 16'h1000) begin
            bad++; $display("FAIL sexa_wrap got=%h want=1000", bcd_out);
        end
        total++;
        if (ovf !== 1'b0) begin
            bad++; $display("FAIL sexa_ovf got=%b want=0", ovf);
        end
    endtask

    task automatic test_ovf();
        load_val = 16'h9599; load = 1'b1; step(1); load = 1'b0;
        total++;
        if (bcd_out !== 16'h9599 || running !== 1'b1) begin
            bad++; $display("FAIL load_9599 got=%h run=%b want=9599 1", bcd_out, running);
        end
        step(3);
        total++;
        if (bcd_out !== 16'h9599 || ovf !== 1'b0) begin
            bad++; $display("FAIL ovf_pre got=%h ovf=%b want=9599 0", bcd_out, ovf);
        end
        step(1);
        total++;
        if (bcd_out !== 16'h0000 || ovf !== 1'b1) begin
            bad++; $display("FAIL ovf_wrap got=%h ovf=%b want=0000 1", bcd_out, ovf);
        end
        step(1);
        total++;
        if (ovf !== 1'b0 || bcd_out !== 16'h0000) begin
            bad++; $display("FAIL ovf_pulse got=%h ovf=%b want=0000 0", bcd_out, ovf);
        end
        load_val = 16'hFFFF; load = 1'b1; step(1); load = 1'b0;
        total++;
        if (bcd_out !== 16'h9599) begin
            bad++; $display("FAIL load_clamp got=%h want=9599", bcd_out);
        end
    endtask

    task automatic test_start_stop();
        start = 1'b1; stop = 1'b1; step(1);
        total++;
        if (running !== 1'b0) begin
            bad++; $display("FAIL ss_running got=%b want=0", running);
        end
        step(1);
        start = 1'b0; stop = 1'b0;
        total++;
        if (running !== 1'b0) begin
            bad++; $display("FAIL ss_stopped got=%b want=0", running);
        end
    endtask

    task automatic test_clear();
        start = 1'b1; step(1); start = 1'b0;
        step(2);
        clear = 1'b1; step(1); clear = 1'b0;
        total++;
        if (bcd_out !== 16'h0000 || running !== 1'b1 || ovf !== 1'b0) begin
            bad++; $display("FAIL clear got=%h run=%b ovf=%b want=0000 1 0",
                            bcd_out, running, ovf);
        end
        step(3);
        total++;
        if (bcd_out !== 16'h0000) begin
            bad++; $display("FAIL clear_hold got=%h want=0000", bcd_out);
        end
        step(1);
        total++;
        if (bcd_out !== 16'h0001) begin
            bad++; $display("FAIL clear_tick got=%h want=0001", bcd_out);
        end
        stop = 1'b1; step(1); stop = 1'b0;
    endtask

    task automatic test_scan(input logic [15:0] val, input logic [15:0] shown);
        logic [2:0] prev;
        logic [3:0] exp_d;
        logic [2:0] exp_an;
        bit         found;
        load_val = val; load = 1'b1; step(1); load = 1'b0;
        step(2);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            prev = an;
            step(1);
            if (prev == 3'd3 && an == 3'd0) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!found) begin
            bad++; $display("FAIL scan_sync got an=%0d want 3->0 wrap", an);
        end
        for (int k = 0; k < 10; k++) begin
            if (k > 0) step(1);
            exp_an = 3'((k / 2) % 4);
            exp_d  = shown[4*exp_an +: 4];
            total++;
            if (an !== exp_an || d !== exp_d) begin
                bad++; $display("FAIL scan_%0d got an=%0d d=%h want an=%0d d=%h",
                                k, an, d, exp_an, exp_d);
            end
        end
        total++;
        if (bcd_out !== val || running !== 1'b0) begin
            bad++; $display("FAIL scan_hold got=%h run=%b want=%h 0", bcd_out, running, val);
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_sexa_wrap();
        test_ovf();
        test_start_stop();
        test_clear();
        test_scan(16'h4321, 16'h4321);
`ifdef BLANK_LZ_EN
        test_scan(16'h0007, 16'hFFF7);
`else
        test_scan(16'h0007, 16'h0007);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
